// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package systolic_pkg;

  localparam int DEF_ROW = 32;
  localparam int DEF_COL = 32;

  // Sequencer states; encodings are fixed so they can be mirrored as plain constants.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // What the row-enable generator should do in the coming cycle.
  typedef enum logic [1:0] {
    PH_OFF    = 2'd0,
    PH_LOAD   = 2'd1,
    PH_STREAM = 2'd2
  } phase_e;

endpackage

// File: rtl/systolic_seq_ctrl_row_skew_gen.sv
// Per-row input enables for the array: every used row during weight load,
// then a diagonal window of N cycles starting at t = row while streaming.
module row_skew_gen
  import systolic_pkg::*;
#(
  parameter int ROW   = DEF_ROW,
  parameter int DIM_W = $clog2(ROW + 1),
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [DIM_W-1:0] k,
  input  logic [LEN_W-1:0] n,
  input  logic [LEN_W:0]   t,
  input  phase_e           phase,
  output logic [ROW-1:0]   input_en
);

  // Extra headroom so row + N never wraps.
  localparam int XW = LEN_W + 2;

  logic [ROW-1:0] en_next;
  logic [ROW-1:0] en_reg;
  logic [XW-1:0]  t_x;
  logic [XW-1:0]  n_x;

  assign t_x = XW'(t);
  assign n_x = XW'(n);

  genvar gi;
  for (gi = 0; gi < ROW; gi++) begin : g_row
    localparam int unsigned RI = gi;
    localparam logic [XW-1:0] R_X = XW'(gi);
    logic row_used;
    logic in_window;

    assign row_used    = 32'(k) > RI;
    assign in_window   = (t_x >= R_X) && (t_x < R_X + n_x);
    assign en_next[gi] = row_used &&
                         ((phase == PH_LOAD) || ((phase == PH_STREAM) && in_window));
  end

  // Inputs describe the next cycle, so the registered enable lines up with the FSM state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) en_reg <= '0;
    else       en_reg <= en_next;
  end

  assign input_en = en_reg;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a ROW x COL systolic array: loads K weight rows, streams
// N vectors with a per-row skew, drains the pipeline, then pulses done.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int ROW   = DEF_ROW,
  parameter int COL   = DEF_COL,
  parameter int DIM_W = $clog2(ROW + 1),
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] weight_dim,
  input  logic [LEN_W-1:0] num_vec,
  output logic             w_ps,
  output logic [ROW-1:0]   input_en,
  output logic             psum_valid,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int TW = LEN_W + 1;  // cycle counter width
  localparam int XW = LEN_W + 2;  // width for end-of-phase sums

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD_W = ST_LOAD_W;
  localparam logic [2:0] S_STREAM = ST_STREAM;
  localparam logic [2:0] S_DRAIN  = ST_DRAIN;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]       state_reg, state_next;
  logic [TW-1:0]    t_reg, t_next;
  logic [DIM_W-1:0] k_reg, k_next;
  logic [LEN_W-1:0] n_reg, n_next;
  logic             cfg_err_reg, cfg_err_next;
  phase_e           phase_next;

  logic [XW-1:0]    t_x, k_x, n_x;
  logic [XW-1:0]    stream_last, drain_last, psum_lo, psum_hi;
  logic [DIM_W-1:0] k_clamped;
  logic             cfg_bad;
  logic             streaming;

  assign t_x = XW'(t_reg);
  assign k_x = XW'(k_reg);
  assign n_x = XW'(n_reg);

  // Last t of STREAM is N+K-2; DRAIN ends once the last vector clears COL columns.
  assign stream_last = k_x + n_x - XW'(2);
  assign drain_last  = k_x + n_x + XW'(COL) - XW'(2);
  assign psum_lo     = k_x + XW'(1);
  assign psum_hi     = k_x + XW'(1) + n_x;

  assign k_clamped = (32'(weight_dim) > 32'(ROW)) ? DIM_W'(ROW) : weight_dim;
  assign cfg_bad   = (weight_dim == '0) || (num_vec == '0);

  // Next-state, counter and job-latch logic; abort overrides everything outside IDLE.
  always_comb begin
    state_next   = state_reg;
    t_next       = t_reg;
    k_next       = k_reg;
    n_next       = n_reg;
    cfg_err_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start && !abort) begin
          if (cfg_bad) begin
            cfg_err_next = 1'b1;
          end else begin
            k_next     = k_clamped;
            n_next     = num_vec;
            t_next     = '0;
            state_next = S_LOAD_W;
          end
        end
      end
      S_LOAD_W: begin
        // t doubles as the load-cycle counter and restarts at 0 for STREAM
        if (t_x == k_x - XW'(1)) begin
          t_next     = '0;
          state_next = S_STREAM;
        end else begin
          t_next = t_reg + TW'(1);
        end
      end
      S_STREAM: begin
        t_next = t_reg + TW'(1);
        if (t_x == stream_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (t_x == drain_last) begin
          t_next     = '0;
          state_next = S_DONE;
        end else begin
          t_next = t_reg + TW'(1);
        end
      end
      S_DONE: begin
        t_next     = '0;
        state_next = S_IDLE;
      end
      default: begin
        t_next     = '0;
        state_next = S_IDLE;
      end
    endcase
    if (abort && (state_reg != S_IDLE)) begin
      t_next     = '0;
      state_next = S_IDLE;
    end
  end

  // Tell the enable generator which phase the coming cycle belongs to.
  always_comb begin
    phase_next = PH_OFF;
    case (state_next)
      S_LOAD_W:          phase_next = PH_LOAD;
      S_STREAM, S_DRAIN: phase_next = PH_STREAM;
      default:           phase_next = PH_OFF;
    endcase
  end

  // FSM state, cycle counter, latched job parameters and the config-error pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= S_IDLE;
      t_reg       <= '0;
      k_reg       <= '0;
      n_reg       <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      t_reg       <= t_next;
      k_reg       <= k_next;
      n_reg       <= n_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  row_skew_gen #(
    .ROW   (ROW),
    .DIM_W (DIM_W),
    .LEN_W (LEN_W)
  ) u_row_skew_gen (
    .clk      (clk),
    .nrst     (nrst),
    .k        (k_next),
    .n        (n_next),
    .t        (t_next),
    .phase    (phase_next),
    .input_en (input_en)
  );

  assign streaming  = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
  assign w_ps       = !streaming;
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign psum_valid = streaming && (t_x >= psum_lo) && (t_x < psum_hi);
  assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a 4x4 array.
module tb_systolic_seq_ctrl;

  logic        clk;
  logic        nrst;
  logic        start;
  logic        abort;
  logic [2:0]  weight_dim;
  logic [15:0] num_vec;
  logic        w_ps;
  logic [3:0]  input_en;
  logic        psum_valid;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int vectors;
  int miscompares;

  systolic_seq_ctrl #(
    .ROW   (4),
    .COL   (4),
    .DIM_W (3),
    .LEN_W (16)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .abort      (abort),
    .weight_dim (weight_dim),
    .num_vec    (num_vec),
    .w_ps       (w_ps),
    .input_en   (input_en),
    .psum_valid (psum_valid),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, w_ps, psum_valid, done, cfg_err, input_en}
  function automatic logic [8:0] pk(input logic b, input logic w, input logic p,
                                    input logic d, input logic c, input logic [3:0] en);
    return {b, w, p, d, c, en};
  endfunction

  task automatic expect_out(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {busy, w_ps, psum_valid, done, cfg_err, input_en};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b (busy,w_ps,psum,done,cfg_err,en[3:0])",
             tag, obs, exp);
    end
  endtask

  // Full job: launch, check every LOAD_W cycle, every t, the done cycle and return to idle.
  // A second start with a different config is raised during load and must be ignored.
  task automatic run_job(input string tag, input logic [2:0] wd, input logic [15:0] nv,
                         input int load_n, input logic [3:0] load_en,
                         input int str_n, input logic [63:0] en_tab, input logic [15:0] ps_tab);
    start = 1'b1; weight_dim = wd; num_vec = nv;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < load_n; i++) begin
      if (i == 1) begin
        start = 1'b1; weight_dim = 3'd1; num_vec = 16'd1;
      end else begin
        start = 1'b0;
      end
      expect_out($sformatf("%s_load%0d", tag, i), pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, load_en));
      @(negedge clk);
    end
    start = 1'b0;
    for (int t = 0; t < str_n; t++) begin
      expect_out($sformatf("%s_t%0d", tag, t),
                 pk(1'b1, 1'b0, ps_tab[t], 1'b0, 1'b0, en_tab[4*t +: 4]));
      @(negedge clk);
    end
    expect_out($sformatf("%s_done", tag), pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0));
    @(negedge clk);
    expect_out($sformatf("%s_idle", tag), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    $display("job %s: weight_dim=%0d num_vec=%0d load=%0d stream+drain=%0d", tag, wd, nv, load_n, str_n);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nrst        = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    weight_dim  = 3'd0;
    num_vec     = 16'd0;

    // Reset takes effect without a clock edge
    #2 nrst = 1'b0;
    #1 expect_out("reset_async", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    expect_out("reset_release", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    $display("reset: applied and released");

    // K=3 N=5: en t0..10 = 1,3,7,7,7,6,4,0,0,0,0 ; psum t4..8
    run_job("k3n5", 3'd3, 16'd5, 3, 4'b0111, 11, 64'h0000_0000_0467_7731, 16'h01F0);

    // Illegal configs: weight_dim=0, then num_vec=0
    start = 1'b1; weight_dim = 3'd0; num_vec = 16'd5;
    @(negedge clk);
    start = 1'b0;
    expect_out("cfg_wd0", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0));
    @(negedge clk);
    expect_out("cfg_wd0_clr", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    start = 1'b1; weight_dim = 3'd2; num_vec = 16'd0;
    @(negedge clk);
    start = 1'b0;
    expect_out("cfg_nv0", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0));
    @(negedge clk);
    expect_out("cfg_nv0_clr", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    @(negedge clk);
    expect_out("cfg_stay_idle", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    $display("cfg_err: weight_dim=0 and num_vec=0 rejected");

    // weight_dim=7 clamps to K=4, N=2: en t0..8 = 1,3,6,C,8,0,0,0,0 ; psum t5..6
    run_job("clamp", 3'd7, 16'd2, 4, 4'b1111, 9, 64'h0000_0000_0008_C631, 16'h0060);

    // Abort at t=3 of a K=3 N=5 job
    start = 1'b1; weight_dim = 3'd3; num_vec = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("abort_load%0d", i), pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111));
      @(negedge clk);
    end
    expect_out("abort_t0", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1));
    @(negedge clk);
    expect_out("abort_t1", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3));
    @(negedge clk);
    expect_out("abort_t2", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7));
    @(negedge clk);
    expect_out("abort_t3", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expect_out("abort_idle", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    @(negedge clk);
    expect_out("abort_no_done", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    $display("abort: job cancelled at t=3");

    // Fresh job after abort, K=2 N=1: en t0..5 = 1,2,0,0,0,0 ; psum t3
    run_job("k2n1", 3'd2, 16'd1, 2, 4'b0011, 6, 64'h0000_0000_0000_0021, 16'h0008);

    // Reset during DRAIN (t=8) of a K=3 N=5 job
    start = 1'b1; weight_dim = 3'd3; num_vec = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 11; i++) @(negedge clk);
    expect_out("rst_drain_t8", pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0));
    #2 nrst = 1'b0;
    #1 expect_out("rst_drain_async", pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_out($sformatf("rst_drain_idle%0d", i), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
      @(negedge clk);
    end
    $display("reset: job discarded during drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
